// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button conditioner:
//   - btn_state_t : per-button debounce FSM state encoding
//   - BTN_*       : bit index of each button in every 4-bit button vector
//   - NUM_BTNS    : number of conditioned buttons
//   - max3()      : helper used to size the shared cycle counters
// ----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_t;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;
    localparam int NUM_BTNS  = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// ----------------------------------------------------------------------------
// debounce_cell
// One button channel: 2-flop synchroniser, debounce FSM, registered
// level and one-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held: macro AUTO_REPEAT_EN.
//
// Ports:
//   i_clk      in  1  system clock
//   i_rst_n    in  1  asynchronous active-low reset
//   i_raw      in  1  raw asynchronous button input (active-high)
//   o_level    out 1  debounced level
//   o_press    out 1  one-cycle pulse on accepted press (and on each repeat)
//   o_release  out 1  one-cycle pulse on accepted release
//
// Handshake: none; all outputs are plain registered levels/pulses.
// Debug: FSM state is held in r_state (type btn_state_t).
// ----------------------------------------------------------------------------
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

    logic [1:0]    r_sync;
    logic          w_s;
    btn_state_t    r_state;
    btn_state_t    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic          r_level;
    logic          w_level_next;
    logic          r_press;
    logic          w_press_next;
    logic          r_release;
    logic          w_release_next;
    logic          w_rep_pulse;

    assign w_s       = r_sync[1];
    // Saturating increment so the counter can never wrap.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_level_next   = r_level;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_next = IDLE;
                end else if (r_cnt == C_DB_LAST) begin
                    w_state_next = HELD;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_next = HELD;
                end else if (r_cnt == C_DB_LAST) begin
                    w_state_next   = IDLE;
                    w_level_next   = 1'b0;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] C_RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] C_RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] w_rcnt_next;
    logic          r_rep_seen;
    logic          w_rep_seen_next;

    // Repeat timer only runs while HELD with the input still high; any other
    // state (including the cycle that enters HELD) clears it, so both a fresh
    // acceptance and a bounce back from RELEASE_WAIT restart from zero.
    always_comb begin
        w_rcnt_next     = '0;
        w_rep_seen_next = 1'b0;
        w_rep_pulse     = 1'b0;
        if ((r_state == HELD) && w_s) begin
            w_rep_seen_next = r_rep_seen;
            if (r_rcnt == (r_rep_seen ? C_RP_LAST : C_RD_LAST)) begin
                w_rep_pulse     = 1'b1;
                w_rcnt_next     = '0;
                w_rep_seen_next = 1'b1;
            end else begin
                w_rcnt_next = (r_rcnt == C_CNT_MAX) ? r_rcnt : r_rcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcnt     <= '0;
            r_rep_seen <= 1'b0;
        end else begin
            r_rcnt     <= w_rcnt_next;
            r_rep_seen <= w_rep_seen_next;
        end
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next | w_rep_pulse;
            r_release <= w_release_next;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
// Synchronises, debounces and edge-detects the four raw board buttons.
// Bit map: [3]=up [2]=down [1]=left [0]=right (see btn_pkg BTN_*).
// Optional auto-repeat on held buttons: macro AUTO_REPEAT_EN.
//
// Ports:
//   clk          in  1  system clock
//   rst_n        in  1  asynchronous active-low reset
//   btn_raw      in  4  raw asynchronous buttons, active-high
//   btn_level    out 4  debounced levels
//   btn_press    out 4  one-cycle press pulses (plus repeats)
//   btn_release  out 4  one-cycle release pulses
// ----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_raw     (btn_raw[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// ----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed scenarios followed by randomized button activity. A run-length
// reference model predicts level/press/release for every cycle.
// ----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    // Input passes a two-sample delay; a button flips its level once the
    // delayed input has disagreed with the level for D+1 consecutive samples.
    logic [3:0] m_d1, m_d2, m_level, m_press, m_rel;
    int         m_run[4];
    int         m_rep_left[4];

    task automatic model_step();
        for (int b = 0; b < 4; b++) begin
            m_press[b] = 1'b0;
            m_rel[b]   = 1'b0;
            if (m_d2[b] != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == D + 1) begin
                    m_level[b] = m_d2[b];
                    m_run[b]   = 0;
                    if (m_level[b]) begin
                        m_press[b]      = 1'b1;
                        m_rep_left[b]   = RD;
                    end else begin
                        m_rel[b] = 1'b1;
                    end
                end
            end else begin
                if (m_level[b]) begin
                    if (m_run[b] > 0) begin
                        m_rep_left[b] = RD;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        m_rep_left[b]--;
                        if (m_rep_left[b] == 0) begin
                            m_press[b]    = 1'b1;
                            m_rep_left[b] = RP;
                        end
`endif
                    end
                end
                m_run[b] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = btn_raw;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
                for (int b = 0; b < 4; b++) begin
                    m_run[b] = 0;
                    m_rep_left[b] = RD;
                end
            end else begin
                model_step();
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("level", {28'd0, btn_level}, {28'd0, m_level});
            check("press", {28'd0, btn_press}, {28'd0, m_press});
            check("release", {28'd0, btn_release}, {28'd0, m_rel});
            check("press_and_release", {28'd0, btn_press & btn_release}, 32'd0);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_level(input int b, input logic lvl, output int k);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (btn_level[b] === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int cnt;
        int first;
        int hold[4];

        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        idle_cycles(3);
        check("rst_level", {28'd0, btn_level}, 32'd0);
        check("rst_press", {28'd0, btn_press}, 32'd0);
        check("rst_release", {28'd0, btn_release}, 32'd0);
        @(negedge clk); #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1. clean press of up
        @(posedge clk); #1;
        btn_raw = 4'b1000;
        wait_level(3, 1'b1, k);
        check("t1_latency", k, 7);
        check("t1_press", {28'd0, btn_press}, 32'h8);
        @(posedge clk); #1;
        check("t1_pulse_width", {28'd0, btn_press}, 32'h0);
        btn_raw = 4'b0000;
        wait_level(3, 1'b0, k);
        check("t1_release_latency", k, 7);
        check("t1_release", {28'd0, btn_release}, 32'h8);

        // 2. bounce on down rejected
        btn_raw = 4'b0100;
        idle_cycles(3);
        btn_raw = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (btn_level[2] || btn_press[2] || btn_release[2]) cnt++;
        end
        check("t2_bounce_reject", cnt, 0);

        // 3. release bounce on left
        btn_raw = 4'b0010;
        wait_level(1, 1'b1, k);
        check("t3_press_latency", k, 7);
        idle_cycles(3);
        btn_raw = 4'b0000;
        idle_cycles(2);
        btn_raw = 4'b0010;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (!btn_level[1] || btn_press[1] || btn_release[1]) cnt++;
        end
        check("t3_release_bounce", cnt, 0);
        btn_raw = 4'b0000;
        wait_level(1, 1'b0, k);
        check("t3_release_latency", k, 7);
        check("t3_release", {28'd0, btn_release}, 32'h2);

        // 4. reset in the middle of PRESS_WAIT while right is held
        btn_raw = 4'b0001;
        wait_level(0, 1'b1, k);
        btn_raw = 4'b1001;
        idle_cycles(5);
        rst_n = 1'b0;
        #1;
        check("t4_rst_level", {28'd0, btn_level}, 32'h0);
        check("t4_rst_press", {28'd0, btn_press}, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        wait_level(3, 1'b1, k);
        check("t4_latency_after_reset", k, 7);
        check("t4_level", {28'd0, btn_level}, 32'h9);

        // 5. simultaneous press of down and right
        btn_raw = 4'b0000;
        wait_level(0, 1'b0, k);
        idle_cycles(10);
        btn_raw = 4'b0101;
        wait_level(0, 1'b1, k);
        check("t5_latency", k, 7);
        check("t5_press", {28'd0, btn_press}, 32'h5);
        check("t5_level", {28'd0, btn_level}, 32'h5);

        // 6. auto-repeat on held right
        cnt   = 0;
        first = -1;
        for (int j = 1; j <= 29; j++) begin
            @(posedge clk); #1;
            if (btn_press[0]) begin
                cnt++;
                if (first < 0) first = j;
            end
        end
`ifdef AUTO_REPEAT_EN
        check("t6_repeat_count", cnt, 7);
        check("t6_repeat_first", first, 10);
`else
        check("t6_repeat_count", cnt, 0);
        check("t6_repeat_first", first, -1);
`endif

        // random activity: mixture of short bounces and long holds
        btn_raw = 4'b0000;
        idle_cycles(12);
        for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 6);
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(1, 6);
                end else begin
                    hold[b]--;
                end
            end
        end
        idle_cycles(4);

        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
